rs_serial_syndrome: RTL and testbench
=====================================

RS_SERIAL_SYNDROME -- requirements
Module: rs_serial_syndrome

Interface
REQ-001 Parameters: none; N (7, symbols per codeword) and SYMBOL_WIDTH (3, bits per GF(2^3) symbol) come from the shared GF constants.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  in_symbol carries a valid received symbol.
REQ-005 in_ready  output  1  block accepts a symbol this cycle.
REQ-006 in_symbol  input  SYMBOL_WIDTH  received symbol, polynomial basis.
REQ-007 out_valid  output  1  frame outputs are valid.
REQ-008 out_ready  input  1  downstream decoder consumes the frame.
REQ-009 codeword  output  N*SYMBOL_WIDTH  assembled received word, feeds decoder codeword input.
REQ-010 s1  output  SYMBOL_WIDTH  syndrome v(alpha), polynomial basis.
REQ-011 s2  output  SYMBOL_WIDTH  syndrome v(alpha^2), polynomial basis.
REQ-012 err_flag  output  1  high when s1 or s2 is nonzero.

Function
REQ-013 Field: GF(2^3), primitive polynomial x^3+x+1, alpha = 3'b010; all arithmetic is XOR-add and GF multiply, no carries.
REQ-014 Symbol transfer occurs iff in_valid && in_ready on a rising edge; frame output transfer occurs iff out_valid && out_ready.
REQ-015 FSM has two states: COLLECT (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-016 COLLECT uses a symbol counter 0..N-1. Each accepted symbol increments the counter. The Nth accepted symbol resets the counter to 0 and moves the FSM to HOLD.
REQ-017 Symbol order: first accepted symbol is coefficient v(N-1) at codeword[(N-1)*SW +: SW]; the kth accepted symbol (k=0..N-1) lands at codeword[(N-1-k)*SW +: SW]; last symbol is v0 at bits [SW-1:0].
REQ-018 Horner update per accepted symbol: S1 <= S1*alpha ^ in_symbol; S2 <= S2*alpha^2 ^ in_symbol. The first symbol of a frame uses accumulators cleared to 0.
REQ-019 Latency: out_valid rises the cycle after the Nth symbol is accepted; codeword, s1, s2 and err_flag are final in that cycle.
REQ-020 In HOLD, codeword, s1, s2 and err_flag are held stable until the output transfer.
REQ-021 HOLD with out_ready=1: on that edge, return to COLLECT and clear counter, accumulators and codeword. in_ready stays 0 during that cycle; no symbol is accepted.
REQ-022 HOLD with out_ready=0: remain in HOLD indefinitely; in_valid is ignored.
REQ-023 COLLECT with in_valid=0: no state change; partial frame is retained across gaps of any length.
REQ-024 err_flag = (s1 != 0) || (s2 != 0), derived combinationally from the registered syndromes.

Reset
REQ-025 On reset: FSM to COLLECT, counter=0, s1=0, s2=0, codeword=0, out_valid=0, in_ready=1 from the next cycle, err_flag=0.
REQ-026 Reset mid-frame or in HOLD discards all partial or pending data; no output transfer follows.
REQ-027 Reset overrides any simultaneous in_valid or out_ready.

Structure
REQ-028 N, K, SYMBOL_WIDTH, primitive polynomial and alpha constants live in the shared GF constants package. No local redefinition is allowed.
REQ-029 Constant multiplication by alpha and by alpha^2 is implemented in one sub-module gf_const_mul, parameterised by exponent and instantiated twice.
REQ-030 Outputs connect directly to the decoder's codeword/S1/S2 path, with no glue logic.

Verification
REQ-031 Frame all zeros -> out_valid one cycle after the 7th symbol; codeword=0, s1=0, s2=0, err_flag=0.
REQ-032 Frame 0,0,0,0,0,0,1 (only v0=1) -> s1=3'b001, s2=3'b001, err_flag=1.
REQ-033 Frame 0,0,0,0,0,1,0 (only v1=1) -> s1=3'b010, s2=3'b100; frame 1,0,0,0,0,0,0 (only v6=1) -> s1=3'b101, s2=3'b111, codeword=21'o1000000.
REQ-034 Backpressure: complete a frame, hold out_ready=0 for 5 cycles while driving in_valid=1 -> in_ready=0 throughout, outputs unchanged. out_ready=1 -> next cycle out_valid=0 and in_ready=1.
REQ-035 Gapped input: 7 symbols with in_valid deasserted for 3 cycles between symbols 2 and 3 -> results identical to the ungapped frame.
REQ-036 Reset after 3 accepted symbols, then a full v6=1 frame -> s1=3'b101, s2=3'b111; no stale data in codeword.

Source files
------------

// File: rtl/rs_serial_syndrome_pkg.sv
// Shared GF(2^3) constants for the RS(7,5) syndrome path.
// Holds the codeword geometry, the field definition, the collector FSM
// state type and a single-step "multiply by alpha" helper.
package rs_serial_syndrome_pkg;

    localparam int N            = 7;
    localparam int K            = 5;
    localparam int SYMBOL_WIDTH = 3;
    localparam int CW_WIDTH     = N * SYMBOL_WIDTH;
    localparam int CNT_WIDTH    = $clog2(N);

    // x^3 + x + 1, and the primitive element alpha = x
    localparam logic [SYMBOL_WIDTH:0]   PRIM_POLY = 4'b1011;
    localparam logic [SYMBOL_WIDTH-1:0] ALPHA     = 3'b010;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_HOLD    = 1'b1
    } state_e;

    // Multiply a polynomial-basis symbol by alpha: shift up one degree and
    // fold the x^3 term back with the primitive polynomial.
    function automatic logic [SYMBOL_WIDTH-1:0] gf_mul_alpha(
        input logic [SYMBOL_WIDTH-1:0] sym
    );
        logic [SYMBOL_WIDTH:0] wide_s;
        wide_s = {sym, 1'b0};
        if (wide_s[SYMBOL_WIDTH]) begin
            wide_s = wide_s ^ PRIM_POLY;
        end else begin
            wide_s = wide_s;
        end
        return wide_s[SYMBOL_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/rs_serial_syndrome_if.sv
// Symbol-in / frame-out bundle of the serial syndrome block.
//   in_valid/in_ready/in_symbol : one received symbol per transfer
//   out_valid/out_ready         : frame handshake toward the decoder
//   codeword/s1/s2/err_flag     : assembled word and its two syndromes
// slave  = the syndrome block, master = the surrounding environment.
interface rs_serial_syndrome_if;
    import rs_serial_syndrome_pkg::*;

    logic                    in_valid;
    logic                    in_ready;
    logic [SYMBOL_WIDTH-1:0] in_symbol;
    logic                    out_valid;
    logic                    out_ready;
    logic [CW_WIDTH-1:0]     codeword;
    logic [SYMBOL_WIDTH-1:0] s1;
    logic [SYMBOL_WIDTH-1:0] s2;
    logic                    err_flag;

    modport slave (
        input  in_valid, in_symbol, out_ready,
        output in_ready, out_valid, codeword, s1, s2, err_flag
    );

    modport master (
        output in_valid, in_symbol, out_ready,
        input  in_ready, out_valid, codeword, s1, s2, err_flag
    );

endinterface

// File: rtl/rs_serial_syndrome_gf_const_mul.sv
// Constant multiplier by alpha^EXP in GF(2^3).
//   sym_in  : symbol in polynomial basis
//   sym_out : sym_in * alpha^EXP, polynomial basis (pure combinational)
module gf_const_mul
    import rs_serial_syndrome_pkg::*;
#(
    parameter int EXP = 1
) (
    input  logic [SYMBOL_WIDTH-1:0] sym_in,
    output logic [SYMBOL_WIDTH-1:0] sym_out
);

    // Apply the alpha step EXP times; unrolls to a small XOR network.
    always_comb begin
        sym_out = sym_in;
        for (int i = 0; i < EXP; i++) begin
            sym_out = gf_mul_alpha(sym_out);
        end
    end

endmodule

// File: rtl/rs_serial_syndrome.sv
// Serial RS(7,5) syndrome front end.
// Collects N symbols (highest-degree coefficient first), assembles them into
// a codeword and evaluates S1 = v(alpha), S2 = v(alpha^2) by Horner's rule,
// then presents the frame until the decoder takes it.
//   clk, reset : clock and synchronous active-high reset
//   bus        : symbol input handshake and frame output handshake/data
module rs_serial_syndrome
    import rs_serial_syndrome_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    rs_serial_syndrome_if.slave   bus
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(N - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    state_e                  state_r,    state_nx_s;
    logic [CNT_WIDTH-1:0]    cnt_r,      cnt_nx_s;
    logic [SYMBOL_WIDTH-1:0] s1_r,       s1_nx_s;
    logic [SYMBOL_WIDTH-1:0] s2_r,       s2_nx_s;
    logic [CW_WIDTH-1:0]     codeword_r, codeword_nx_s;
    logic [SYMBOL_WIDTH-1:0] s1_mul_s;
    logic [SYMBOL_WIDTH-1:0] s2_mul_s;

    gf_const_mul #(.EXP(1)) u_mul_alpha  (.sym_in(s1_r), .sym_out(s1_mul_s));
    gf_const_mul #(.EXP(2)) u_mul_alpha2 (.sym_in(s2_r), .sym_out(s2_mul_s));

    // Next-state and datapath update for the collect/hold frame FSM.
    always_comb begin
        state_nx_s    = state_r;
        cnt_nx_s      = cnt_r;
        s1_nx_s       = s1_r;
        s2_nx_s       = s2_r;
        codeword_nx_s = codeword_r;
        case (state_r)
            ST_COLLECT: begin
                if (bus.in_valid) begin
                    // Horner step; accumulators are zero at frame start
                    s1_nx_s       = s1_mul_s ^ bus.in_symbol;
                    s2_nx_s       = s2_mul_s ^ bus.in_symbol;
                    // Shift up so the first symbol ends in the top slot
                    codeword_nx_s = {codeword_r[CW_WIDTH-SYMBOL_WIDTH-1:0], bus.in_symbol};
                    if (cnt_r == CNT_LAST) begin
                        cnt_nx_s   = '0;
                        state_nx_s = ST_HOLD;
                    end else begin
                        cnt_nx_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    state_nx_s = ST_COLLECT;
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    state_nx_s    = ST_COLLECT;
                    cnt_nx_s      = '0;
                    s1_nx_s       = '0;
                    s2_nx_s       = '0;
                    codeword_nx_s = '0;
                end else begin
                    state_nx_s = ST_HOLD;
                end
            end
            default: begin
                state_nx_s    = ST_COLLECT;
                cnt_nx_s      = '0;
                s1_nx_s       = '0;
                s2_nx_s       = '0;
                codeword_nx_s = '0;
            end
        endcase
    end

    // State, counter, syndrome and codeword registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_COLLECT;
            cnt_r      <= '0;
            s1_r       <= '0;
            s2_r       <= '0;
            codeword_r <= '0;
        end else begin
            state_r    <= state_nx_s;
            cnt_r      <= cnt_nx_s;
            s1_r       <= s1_nx_s;
            s2_r       <= s2_nx_s;
            codeword_r <= codeword_nx_s;
        end
    end

    assign bus.in_ready  = (state_r == ST_COLLECT);
    assign bus.out_valid = (state_r == ST_HOLD);
    assign bus.codeword  = codeword_r;
    assign bus.s1        = s1_r;
    assign bus.s2        = s2_r;
    assign bus.err_flag  = (s1_r != '0) || (s2_r != '0);

endmodule

// File: tb/tb_rs_serial_syndrome.sv
// Directed self-checking bench for rs_serial_syndrome.
// Expected syndromes were worked out by hand from the GF(2^3) log table
// (alpha^0..6 = 1,2,4,3,6,7,5).
module tb_rs_serial_syndrome;
    import rs_serial_syndrome_pkg::*;

    logic clk;
    logic reset;
    int   checks_r;
    int   failures_r;

    rs_serial_syndrome_if bus ();

    rs_serial_syndrome dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks_r++;
        if (act !== exp) begin
            failures_r++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Send the 7 symbols of frame (top slot first); after symbol index gap_at
    // has been sent, idle for gap_len cycles.
    task automatic send_frame(input string tag, input logic [20:0] frame,
                              input int gap_at, input int gap_len);
        for (int k = 0; k < N; k++) begin
            if (k == N - 1) begin
                check_val({tag, "_early_valid"}, 32'(bus.out_valid), 32'd0);
            end
            bus.in_valid  = 1'b1;
            bus.in_symbol = frame[(N-1-k)*SYMBOL_WIDTH +: SYMBOL_WIDTH];
            step();
            bus.in_valid = 1'b0;
            if (k == gap_at) begin
                for (int g = 0; g < gap_len; g++) begin
                    step();
                end
            end
        end
    endtask

    task automatic check_frame(input string tag, input logic [20:0] cw,
                               input logic [2:0] e1, input logic [2:0] e2, input logic ef);
        check_val({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check_val({tag, "_ready"}, 32'(bus.in_ready), 32'd0);
        check_val({tag, "_cw"}, 32'(bus.codeword), 32'(cw));
        check_val({tag, "_s1"}, 32'(bus.s1), 32'(e1));
        check_val({tag, "_s2"}, 32'(bus.s2), 32'(e2));
        check_val({tag, "_err"}, 32'(bus.err_flag), 32'(ef));
    endtask

    task automatic consume(input string tag);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check_val({tag, "_rel_valid"}, 32'(bus.out_valid), 32'd0);
        check_val({tag, "_rel_ready"}, 32'(bus.in_ready), 32'd1);
        check_val({tag, "_rel_cw"}, 32'(bus.codeword), 32'd0);
    endtask

    task automatic run_frame(input string tag, input logic [20:0] frame,
                             input logic [2:0] e1, input logic [2:0] e2, input logic ef);
        send_frame(tag, frame, -1, 0);
        check_frame(tag, frame, e1, e2, ef);
        consume(tag);
    endtask

    // Directed scenario sequence.
    initial begin
        checks_r      = 0;
        failures_r    = 0;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_symbol = 3'd0;
        bus.out_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
        check_val("rst_ready", 32'(bus.in_ready), 32'd1);
        check_val("rst_valid", 32'(bus.out_valid), 32'd0);
        check_val("rst_cw", 32'(bus.codeword), 32'd0);
        check_val("rst_s1", 32'(bus.s1), 32'd0);
        check_val("rst_s2", 32'(bus.s2), 32'd0);
        check_val("rst_err", 32'(bus.err_flag), 32'd0);

        run_frame("zero", 21'o0000000, 3'b000, 3'b000, 1'b0);
        run_frame("v0",   21'o0000001, 3'b001, 3'b001, 1'b1);
        run_frame("v1",   21'o0000010, 3'b010, 3'b100, 1'b1);
        run_frame("v6",   21'o1000000, 3'b101, 3'b111, 1'b1);
        // generator polynomial x^2 + 6x + 3 is itself a valid codeword
        run_frame("gen",  21'o0000163, 3'b000, 3'b000, 1'b0);

        // Backpressure with in_valid held high in HOLD
        send_frame("bp", 21'o1234567, -1, 0);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_symbol = 3'd5;
        for (int c = 0; c < 5; c++) begin
            step();
            check_frame("bp_hold", 21'o1234567, 3'b100, 3'b100, 1'b1);
        end
        consume("bp");
        bus.in_valid = 1'b0;
        check_val("bp_no_accept_s1", 32'(bus.s1), 32'd0);

        // Gap of 3 idle cycles between symbols 2 and 3
        send_frame("gap", 21'o1000000, 2, 3);
        check_frame("gap", 21'o1000000, 3'b101, 3'b111, 1'b1);
        consume("gap");

        // Reset after 3 accepted symbols, asserted together with in_valid
        bus.in_valid  = 1'b1;
        bus.in_symbol = 3'd7;
        step();
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.in_valid = 1'b0;
        step();
        check_val("mid_rst_cw", 32'(bus.codeword), 32'd0);
        check_val("mid_rst_s1", 32'(bus.s1), 32'd0);
        check_val("mid_rst_ready", 32'(bus.in_ready), 32'd1);
        run_frame("after_rst", 21'o1000000, 3'b101, 3'b111, 1'b1);

        // Reset while holding a frame, with out_ready asserted at the same time
        send_frame("hold_rst", 21'o1234567, -1, 0);
        reset         = 1'b1;
        bus.out_ready = 1'b1;
        step();
        reset         = 1'b0;
        bus.out_ready = 1'b0;
        check_val("hold_rst_valid", 32'(bus.out_valid), 32'd0);
        check_val("hold_rst_cw", 32'(bus.codeword), 32'd0);
        check_val("hold_rst_err", 32'(bus.err_flag), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end

endmodule
